// File: rtl/sweep_pkg.sv
// Shared types and widths for the 4-input truth-table sweeper.
package sweep_pkg;
  localparam int VEC_W   = 4;
  localparam int TABLE_W = 16;
  localparam int ONES_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest counter width that can hold hold-1; a one-cycle hold still needs one bit.
  function automatic int cnt_width(input int hold);
    return (hold <= 1) ? 1 : $clog2(hold);
  endfunction
endpackage

// File: rtl/sweep_capture_if.sv
// Sweep request/status and unit-under-sweep signals between the sweeper and its client.
interface sweep_capture_if;
  import sweep_pkg::*;

  logic                start;
  logic                abort;
  logic                f;
  logic                w;
  logic                x;
  logic                y;
  logic                z;
  logic                busy;
  logic                done;
  logic [TABLE_W-1:0]  truth_table;
  logic [ONES_W-1:0]   ones_count;

  modport master (
    output start, abort, f,
    input  w, x, y, z, busy, done, truth_table, ones_count
  );

  modport slave (
    input  start, abort, f,
    output w, x, y, z, busy, done, truth_table, ones_count
  );
endinterface

// File: rtl/hold_timer.sv
// Free-running modulo-HOLD_CYCLES counter; expire marks the last cycle of each hold window.
module hold_timer
  import sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);
  localparam int              CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      expire = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sweep_capture.sv
// Steps a 4-bit vector through all minterms, holding each for HOLD_CYCLES, and records f.
module sweep_capture
  import sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic            clk,
  input  logic            rst,
  sweep_capture_if.slave  bus
);
  localparam logic [VEC_W-1:0] LAST_VEC = '1;

  state_t              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [TABLE_W-1:0]  tt_q, tt_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic                timer_clear;
  logic                expire;

  // Timer is held at zero outside RUN so every sweep starts on a fresh hold window.
  assign timer_clear = (state_q != S_RUN);

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    case (state_q)
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          vec_d   = '0;
        end else if (expire) begin
          tt_d[vec_q] = bus.f;
          ones_d      = ones_q + ONES_W'(bus.f);
          if (vec_q == LAST_VEC) begin
            state_d = S_DONE;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = '0;
          tt_d    = '0;
          ones_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  assign {bus.w, bus.x, bus.y, bus.z} = vec_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.truth_table = tt_q;
  assign bus.ones_count  = ones_q;
endmodule

// File: tb/tb_sweep_capture.sv
// Bench for sweep_capture: two instances (hold 10 and hold 1) against a sweep-level model.
module tb_sweep_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  int          hold [2] = '{10, 1};
  int          mode [2] = '{0, 0};
  logic [15:0] rand_tt  = 16'h0;

  // Model: a sweep is "running" for 16*hold cycles; elapsed cycle count alone fixes the vector.
  bit          m_run  [2];
  bit          m_done [2];
  int          m_el   [2];
  logic [15:0] m_tt   [2];
  int          m_ones [2];

  sweep_capture_if b10 ();
  sweep_capture_if b1 ();

  sweep_capture #(.HOLD_CYCLES(10)) dut10 (.clk(clk), .rst(rst), .bus(b10.slave));
  sweep_capture #(.HOLD_CYCLES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  function automatic logic f_of(int md, logic [3:0] v, logic [15:0] tbl);
    case (md)
      0:       return &v;
      1:       return ^v;
      2:       return ~v[3];
      default: return tbl[v];
    endcase
  endfunction

  assign b10.f = f_of(mode[0], {b10.w, b10.x, b10.y, b10.z}, rand_tt);
  assign b1.f  = f_of(mode[1], {b1.w, b1.x, b1.y, b1.z}, rand_tt);

  function automatic logic [3:0] vec_of(int i);
    return (i == 0) ? {b10.w, b10.x, b10.y, b10.z} : {b1.w, b1.x, b1.y, b1.z};
  endfunction
  function automatic logic busy_of(int i);
    return (i == 0) ? b10.busy : b1.busy;
  endfunction
  function automatic logic done_of(int i);
    return (i == 0) ? b10.done : b1.done;
  endfunction
  function automatic logic [15:0] tt_of(int i);
    return (i == 0) ? b10.truth_table : b1.truth_table;
  endfunction
  function automatic logic [4:0] ones_of(int i);
    return (i == 0) ? b10.ones_count : b1.ones_count;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(int i, bit s, bit a);
    if (i == 0) begin b10.start = s; b10.abort = a; end
    else        begin b1.start  = s; b1.abort  = a; end
  endtask

  task automatic upd(int i, bit s, bit a);
    int       v;
    logic     fv;
    if (m_run[i]) begin
      if (a) begin
        m_run[i] = 1'b0;
      end else begin
        v = m_el[i] / hold[i];
        if (m_el[i] % hold[i] == hold[i] - 1) begin
          fv          = f_of(mode[i], v[3:0], rand_tt);
          m_tt[i][v]  = fv;
          m_ones[i]  += int'(fv);
        end
        m_el[i]++;
        if (m_el[i] == 16 * hold[i]) begin
          m_run[i]  = 1'b0;
          m_done[i] = 1'b1;
        end
      end
    end else if (s) begin
      m_run[i]  = 1'b1;
      m_done[i] = 1'b0;
      m_el[i]   = 0;
      m_tt[i]   = 16'h0;
      m_ones[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 1'b0; m_done[i] = 1'b0; m_el[i] = 0; m_tt[i] = 16'h0; m_ones[i] = 0;
      end
    end else begin
      upd(0, b10.start, b10.abort);
      upd(1, b1.start, b1.abort);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("vec%0d", i),  32'(vec_of(i)),  m_run[i] ? 32'(m_el[i] / hold[i]) : 32'd0);
        cmp($sformatf("busy%0d", i), 32'(busy_of(i)), 32'(m_run[i]));
        cmp($sformatf("done%0d", i), 32'(done_of(i)), 32'(m_done[i]));
        cmp($sformatf("tt%0d", i),   32'(tt_of(i)),   32'(m_tt[i]));
        cmp($sformatf("ones%0d", i), 32'(ones_of(i)), 32'(m_ones[i]));
      end
    end
  end

  task automatic sweep(int i, int md, bit with_abort, int restart_at, output int bc);
    bit pulsed;
    pulsed  = 1'b0;
    mode[i] = md;
    drive(i, 1'b1, with_abort);
    @(negedge clk);
    drive(i, 1'b0, 1'b0);
    bc = 0;
    while (busy_of(i) && bc < 1000) begin
      if (restart_at >= 0 && !pulsed && vec_of(i) == 4'(restart_at)) begin
        drive(i, 1'b1, 1'b0);
        pulsed = 1'b1;
      end else begin
        drive(i, 1'b0, 1'b0);
      end
      bc++;
      @(negedge clk);
    end
    drive(i, 1'b0, 1'b0);
    if (restart_at >= 0) cmp("restart_pulsed", 32'(pulsed), 32'd1);
  endtask

  task automatic wait_vec(int i, logic [3:0] v);
    int n;
    n = 0;
    while (vec_of(i) != v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cmp("wait_vec_timeout", 32'(n < 1000), 32'd1);
  endtask

  initial begin
    int          bc;
    logic [15:0] snap;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;
    cmp("reset_tt",   32'(b10.truth_table), 32'h0);
    cmp("reset_busy", 32'(b10.busy), 32'd0);
    cmp("reset_done", 32'(b10.done), 32'd0);

    sweep(0, 0, 1'b0, -1, bc);
    cmp("and_busy_cycles", bc, 160);
    cmp("and_tt",   32'(b10.truth_table), 32'h8000);
    cmp("and_ones", 32'(b10.ones_count), 32'd1);
    cmp("and_done", 32'(b10.done), 32'd1);

    drive(0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    cmp("abort_in_done", 32'(b10.done), 32'd1);

    sweep(0, 1, 1'b1, -1, bc);
    cmp("xor_busy_cycles", bc, 160);
    cmp("xor_tt",   32'(b10.truth_table), 32'h6996);
    cmp("xor_ones", 32'(b10.ones_count), 32'd8);

    sweep(0, 1, 1'b0, 7, bc);
    cmp("restart_busy_cycles", bc, 160);
    cmp("restart_tt", 32'(b10.truth_table), 32'h6996);

    rand_tt = 16'($urandom) | 16'h0015;
    snap    = rand_tt;
    mode[0] = 3;
    drive(0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    wait_vec(0, 4'd5);
    drive(0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    cmp("abort_busy", 32'(b10.busy), 32'd0);
    cmp("abort_done", 32'(b10.done), 32'd0);
    cmp("abort_vec",  32'(vec_of(0)), 32'd0);
    cmp("abort_hi_bits", 32'(b10.truth_table & 16'hFFE0), 32'h0);
    cmp("abort_lo_bits", 32'(b10.truth_table[4:0]), 32'(snap[4:0]));
    cmp("abort_ones", 32'(b10.ones_count), 32'($countones(snap[4:0])));

    mode[0] = 1;
    drive(0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    wait_vec(0, 4'd12);
    rst = 1'b1;
    drive(0, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    cmp("rst_busy", 32'(b10.busy), 32'd0);
    cmp("rst_done", 32'(b10.done), 32'd0);
    cmp("rst_vec",  32'(vec_of(0)), 32'd0);
    cmp("rst_tt",   32'(b10.truth_table), 32'h0);
    cmp("rst_ones", 32'(b10.ones_count), 32'd0);

    rand_tt = 16'($urandom);
    snap    = rand_tt;
    sweep(0, 3, 1'b0, -1, bc);
    cmp("post_rst_busy_cycles", bc, 160);
    cmp("post_rst_tt",   32'(b10.truth_table), 32'(snap));
    cmp("post_rst_ones", 32'(b10.ones_count), 32'($countones(snap)));

    sweep(1, 2, 1'b0, -1, bc);
    cmp("h1_busy_cycles", bc, 16);
    cmp("h1_tt",   32'(b1.truth_table), 32'h00FF);
    cmp("h1_ones", 32'(b1.ones_count), 32'd8);

    mode[0] = 3;
    mode[1] = 3;
    for (int c = 0; c < 4000; c++) begin
      if (c % 700 == 0) rand_tt = 16'($urandom);
      drive(0, $urandom_range(0, 29) == 0, $urandom_range(0, 299) == 0);
      drive(1, $urandom_range(0, 9) == 0,  $urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sweep_capture.md
SWEEP_CAPTURE -- requirements
Module: sweep_capture

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, on ports clk and rst.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 10: the number of clk cycles each input vector is held; legal range 1..255.
REQ-003 The block SHALL have ports, one per line:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a sweep
- abort  input  1  cancels a sweep in progress
- f  input  1  output of the 4-input combinational unit under sweep
- w  output  1  vector bit 3 (MSB) to the unit
- x  output  1  vector bit 2
- y  output  1  vector bit 1
- z  output  1  vector bit 0 (LSB)
- busy  output  1  sweep in progress
- done  output  1  sweep completed; table is valid
- truth_table  output  16  captured f per minterm; bit i holds f for {w,x,y,z}==i
- ones_count  output  5  number of 1 bits in truth_table (0..16)

Function
REQ-004 The block SHALL implement states IDLE, RUN and DONE.
REQ-005 In IDLE or DONE, start=1 SHALL clear the vector, hold counter, truth_table, ones_count and done, then enter RUN on the next edge.
REQ-006 {w,x,y,z} SHALL equal the current 4-bit vector at all times; the vector is 0 outside RUN.
REQ-007 In RUN, the hold counter SHALL count 0..HOLD_CYCLES-1; f SHALL be sampled into truth_table[vector] only on the cycle where counter==HOLD_CYCLES-1, giving the unit HOLD_CYCLES-1 cycles to settle.
REQ-008 On the sample cycle, ones_count SHALL increment by f, and the counter SHALL return to 0.
REQ-009 On the sample cycle, if vector<15 the vector SHALL increment by 1; if vector==15 the state SHALL go to DONE.
REQ-010 busy SHALL be 1 exactly while in RUN; the sweep SHALL take exactly 16*HOLD_CYCLES cycles of busy=1.
REQ-011 done SHALL be 1 while in DONE and SHALL hold until the next start, abort-free reset or rst.
REQ-012 start while in RUN SHALL be ignored.
REQ-013 abort=1 in RUN SHALL return the state to IDLE on the next edge with busy=0, done=0 and the vector at 0; truth_table and ones_count keep their partial values.
REQ-014 abort in IDLE or DONE SHALL have no effect; if abort and start are both 1 in the same cycle, abort SHALL win in RUN and start SHALL win in IDLE/DONE.
REQ-015 With HOLD_CYCLES=1, the block SHALL sample every cycle and the vector SHALL advance every cycle.

Reset
REQ-016 rst=1 SHALL force state IDLE, vector 0, counter 0, busy 0, done 0, truth_table 16'h0000 and ones_count 0 on the next edge, overriding start and abort, including mid-sweep.

Structure
REQ-017 The state encoding, the vector width (4) and the table width (16) SHALL live in a shared package sweep_pkg.
REQ-018 The hold counter SHALL be a sub-module hold_timer, parameterised by HOLD_CYCLES, with inputs clk, rst and clear and a one-cycle output expire.
REQ-019 The counter width SHALL be the minimum number of bits that holds HOLD_CYCLES-1.

Verification
REQ-020 f=w&x&y&z, HOLD_CYCLES=10, start pulse -> busy high for 160 cycles, then done=1, truth_table=16'h8000, ones_count=1.
REQ-021 f=w^x^y^z -> truth_table=16'h6996, ones_count=8; {w,x,y,z} steps 0..15 with each value held for 10 cycles.
REQ-022 start re-pulsed at vector 7 during RUN -> no restart; final result is unchanged and busy lasts 160 cycles.
REQ-023 abort at vector 5 -> next cycle busy=0, done=0, {w,x,y,z}=0000, truth_table bits 5..15 are 0.
REQ-024 rst at vector 12 -> all outputs 0, state IDLE; a following start gives a correct full sweep.
REQ-025 HOLD_CYCLES=1, f=~w -> busy for 16 cycles, truth_table=16'h00FF, ones_count=8.
